// File: rtl/axi_slice_pkg.sv
// Shared widths, channel payload structs and counter-width helper for the
// single-clock AXI buffering slice.
package axi_slice_pkg;

  localparam int ID_W    = 4;
  localparam int ADDR_W  = 32;
  localparam int LEN_W   = 8;
  localparam int BURST_W = 2;
  localparam int DATA_W  = 32;
  localparam int STRB_W  = 4;
  localparam int RESP_W  = 2;

  localparam int AX_W = ID_W + ADDR_W + LEN_W + BURST_W;
  localparam int W_W  = DATA_W + STRB_W + 1;
  localparam int B_W  = ID_W + RESP_W;
  localparam int R_W  = ID_W + DATA_W + RESP_W + 1;

  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   len;
    logic [BURST_W-1:0] burst;
  } ax_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [RESP_W-1:0] resp;
  } b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [RESP_W-1:0] resp;
    logic              last;
  } r_t;

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int clog2_sat(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/axi_inf.sv
// AXI4 bundle. Modports are named from the slice's point of view:
// M faces an upstream master (AW/W/AR come in), S faces a downstream slave.
interface AXI_INF;
  import axi_slice_pkg::*;

  logic [ID_W-1:0]    WR_ADDR_ID;
  logic [ADDR_W-1:0]  WR_ADDR;
  logic [LEN_W-1:0]   WR_ADDR_LEN;
  logic [BURST_W-1:0] WR_ADDR_BURST;
  logic               WR_ADDR_VALID;
  logic               WR_ADDR_READY;

  logic [DATA_W-1:0]  WR_DATA;
  logic [STRB_W-1:0]  WR_STRB;
  logic               WR_DATA_LAST;
  logic               WR_DATA_VALID;
  logic               WR_DATA_READY;

  logic [ID_W-1:0]    WR_BACK_ID;
  logic [RESP_W-1:0]  WR_BACK_RESP;
  logic               WR_BACK_VALID;
  logic               WR_BACK_READY;

  logic [ID_W-1:0]    RD_ADDR_ID;
  logic [ADDR_W-1:0]  RD_ADDR;
  logic [LEN_W-1:0]   RD_ADDR_LEN;
  logic [BURST_W-1:0] RD_ADDR_BURST;
  logic               RD_ADDR_VALID;
  logic               RD_ADDR_READY;

  logic [ID_W-1:0]    RD_BACK_ID;
  logic [DATA_W-1:0]  RD_DATA;
  logic [RESP_W-1:0]  RD_DATA_RESP;
  logic               RD_DATA_LAST;
  logic               RD_DATA_VALID;
  logic               RD_DATA_READY;

  modport M (
    input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    output WR_ADDR_READY,
    input  WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID,
    output WR_DATA_READY,
    output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    input  WR_BACK_READY,
    input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    output RD_ADDR_READY,
    output RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    input  RD_DATA_READY
  );

  modport S (
    output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_BURST, WR_ADDR_VALID,
    input  WR_ADDR_READY,
    output WR_DATA, WR_STRB, WR_DATA_LAST, WR_DATA_VALID,
    input  WR_DATA_READY,
    input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
    output WR_BACK_READY,
    output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_BURST, RD_ADDR_VALID,
    input  RD_ADDR_READY,
    input  RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
    output RD_DATA_READY
  );

endinterface

// File: rtl/axi_sync_fifo.sv
// First-word-fall-through FIFO, 2**DEPTH_LOG2 entries. Full/empty come only
// from registered pointers, so nothing passes through combinationally.
module axi_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                push, pop;

  // Extra MSB: same index with differing wrap bit means full.
  assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                 (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  assign rd_data = mem[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
    if (pop)  rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axi_sync_slice.sv
// Single-clock AXI4 buffering slice: one FWFT FIFO per channel plus
// per-direction outstanding limiters. AXI_SYNC_SLICE_STATUS_EN adds status ports.
module axi_sync_slice
  import axi_slice_pkg::*;
#(
  parameter int AW_DEPTH_LOG2      = 2,
  parameter int W_DEPTH_LOG2       = 4,
  parameter int B_DEPTH_LOG2       = 2,
  parameter int AR_DEPTH_LOG2      = 2,
  parameter int R_DEPTH_LOG2       = 4,
  parameter int MAX_WR_OUTSTANDING = 4,
  parameter int MAX_RD_OUTSTANDING = 4,
  parameter int DATA_MASK          = 1
) (
  input  logic CLK,
  input  logic RST,
  AXI_INF.M    AXI_B,
  AXI_INF.S    AXI_S,
  output logic wr_cnt_err,
  output logic rd_cnt_err
`ifdef AXI_SYNC_SLICE_STATUS_EN
  ,
  output logic [4:0] fifo_empty_flag,
  output logic [7:0] wr_outstanding,
  output logic [7:0] rd_outstanding
`endif
);

  localparam int WR_CW = clog2_sat(MAX_WR_OUTSTANDING);
  localparam int RD_CW = clog2_sat(MAX_RD_OUTSTANDING);
  localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_WR_OUTSTANDING);
  localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_RD_OUTSTANDING);

  ax_t aw_in, aw_out, ar_in, ar_out;
  w_t  w_in, w_out, w_msk;
  b_t  b_in, b_out;
  r_t  r_in, r_out, r_msk;

  logic aw_full, aw_empty, w_full, w_empty, ar_full, ar_empty;
  logic b_full, b_empty, r_full, r_empty;
  logic aw_rdy, aw_vld, w_rdy, w_vld, ar_rdy, ar_vld;
  logic b_rdy, b_vld, r_rdy, r_vld;
  logic aw_hs, b_hs, ar_hs, rl_hs;

  logic [WR_CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RD_CW-1:0] rd_cnt_q, rd_cnt_d;
  logic             wr_cnt_err_q, wr_cnt_err_d;
  logic             rd_cnt_err_q, rd_cnt_err_d;

  // ---------------- ingress payloads ----------------
  assign aw_in = {AXI_B.WR_ADDR_ID, AXI_B.WR_ADDR, AXI_B.WR_ADDR_LEN, AXI_B.WR_ADDR_BURST};
  assign w_in  = {AXI_B.WR_DATA, AXI_B.WR_STRB, AXI_B.WR_DATA_LAST};
  assign ar_in = {AXI_B.RD_ADDR_ID, AXI_B.RD_ADDR, AXI_B.RD_ADDR_LEN, AXI_B.RD_ADDR_BURST};
  assign b_in  = {AXI_S.WR_BACK_ID, AXI_S.WR_BACK_RESP};
  assign r_in  = {AXI_S.RD_BACK_ID, AXI_S.RD_DATA, AXI_S.RD_DATA_RESP, AXI_S.RD_DATA_LAST};

  // ---------------- ready / valid ----------------
  assign aw_rdy = !RST && !aw_full && (wr_cnt_q < WR_MAX);
  assign ar_rdy = !RST && !ar_full && (rd_cnt_q < RD_MAX);
  assign w_rdy  = !RST && !w_full;
  assign b_rdy  = !RST && !b_full;
  assign r_rdy  = !RST && !r_full;

  assign aw_vld = !RST && !aw_empty;
  assign w_vld  = !RST && !w_empty;
  assign ar_vld = !RST && !ar_empty;
  assign b_vld  = !RST && !b_empty;
  assign r_vld  = !RST && !r_empty;

  assign aw_hs = AXI_B.WR_ADDR_VALID && aw_rdy;
  assign ar_hs = AXI_B.RD_ADDR_VALID && ar_rdy;
  assign b_hs  = b_vld && AXI_B.WR_BACK_READY;
  assign rl_hs = r_vld && AXI_B.RD_DATA_READY && r_out.last;

  // ---------------- channel FIFOs ----------------
  axi_sync_fifo #(.WIDTH(AX_W), .DEPTH_LOG2(AW_DEPTH_LOG2)) u_aw_fifo (
    .CLK(CLK), .RST(RST),
    .wr_en(aw_hs), .wr_data(aw_in), .full(aw_full),
    .rd_en(aw_vld && AXI_S.WR_ADDR_READY), .rd_data(aw_out), .empty(aw_empty)
  );

  axi_sync_fifo #(.WIDTH(W_W), .DEPTH_LOG2(W_DEPTH_LOG2)) u_w_fifo (
    .CLK(CLK), .RST(RST),
    .wr_en(AXI_B.WR_DATA_VALID && w_rdy), .wr_data(w_in), .full(w_full),
    .rd_en(w_vld && AXI_S.WR_DATA_READY), .rd_data(w_out), .empty(w_empty)
  );

  axi_sync_fifo #(.WIDTH(B_W), .DEPTH_LOG2(B_DEPTH_LOG2)) u_b_fifo (
    .CLK(CLK), .RST(RST),
    .wr_en(AXI_S.WR_BACK_VALID && b_rdy), .wr_data(b_in), .full(b_full),
    .rd_en(b_hs), .rd_data(b_out), .empty(b_empty)
  );

  axi_sync_fifo #(.WIDTH(AX_W), .DEPTH_LOG2(AR_DEPTH_LOG2)) u_ar_fifo (
    .CLK(CLK), .RST(RST),
    .wr_en(ar_hs), .wr_data(ar_in), .full(ar_full),
    .rd_en(ar_vld && AXI_S.RD_ADDR_READY), .rd_data(ar_out), .empty(ar_empty)
  );

  axi_sync_fifo #(.WIDTH(R_W), .DEPTH_LOG2(R_DEPTH_LOG2)) u_r_fifo (
    .CLK(CLK), .RST(RST),
    .wr_en(AXI_S.RD_DATA_VALID && r_rdy), .wr_data(r_in), .full(r_full),
    .rd_en(r_vld && AXI_B.RD_DATA_READY), .rd_data(r_out), .empty(r_empty)
  );

  // Data-carrying channels can be zeroed while idle so no stale beat leaks out.
  assign w_msk = (DATA_MASK != 0) ? (w_out & {W_W{w_vld}}) : w_out;
  assign r_msk = (DATA_MASK != 0) ? (r_out & {R_W{r_vld}}) : r_out;

  // ---------------- egress ----------------
  assign AXI_B.WR_ADDR_READY = aw_rdy;
  assign AXI_B.WR_DATA_READY = w_rdy;
  assign AXI_B.RD_ADDR_READY = ar_rdy;
  assign AXI_B.WR_BACK_VALID = b_vld;
  assign {AXI_B.WR_BACK_ID, AXI_B.WR_BACK_RESP} = b_out;
  assign AXI_B.RD_DATA_VALID = r_vld;
  assign {AXI_B.RD_BACK_ID, AXI_B.RD_DATA, AXI_B.RD_DATA_RESP, AXI_B.RD_DATA_LAST} = r_msk;

  assign AXI_S.WR_ADDR_VALID = aw_vld;
  assign {AXI_S.WR_ADDR_ID, AXI_S.WR_ADDR, AXI_S.WR_ADDR_LEN, AXI_S.WR_ADDR_BURST} = aw_out;
  assign AXI_S.WR_DATA_VALID = w_vld;
  assign {AXI_S.WR_DATA, AXI_S.WR_STRB, AXI_S.WR_DATA_LAST} = w_msk;
  assign AXI_S.RD_ADDR_VALID = ar_vld;
  assign {AXI_S.RD_ADDR_ID, AXI_S.RD_ADDR, AXI_S.RD_ADDR_LEN, AXI_S.RD_ADDR_BURST} = ar_out;
  assign AXI_S.WR_BACK_READY = b_rdy;
  assign AXI_S.RD_DATA_READY = r_rdy;

  // ---------------- outstanding limiters ----------------
  // Simultaneous issue and retire cancel; a retire with nothing pending is flagged.
  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    wr_cnt_err_d = wr_cnt_err_q;
    case ({aw_hs, b_hs})
      2'b10:   wr_cnt_d = wr_cnt_q + WR_CW'(1);
      2'b01: begin
        if (wr_cnt_q == '0) wr_cnt_err_d = 1'b1;
        else                wr_cnt_d     = wr_cnt_q - WR_CW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_cnt_d     = rd_cnt_q;
    rd_cnt_err_d = rd_cnt_err_q;
    case ({ar_hs, rl_hs})
      2'b10:   rd_cnt_d = rd_cnt_q + RD_CW'(1);
      2'b01: begin
        if (rd_cnt_q == '0) rd_cnt_err_d = 1'b1;
        else                rd_cnt_d     = rd_cnt_q - RD_CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_err_q <= 1'b0;
      rd_cnt_err_q <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_err_q <= wr_cnt_err_d;
      rd_cnt_err_q <= rd_cnt_err_d;
    end
  end

  assign wr_cnt_err = wr_cnt_err_q;
  assign rd_cnt_err = rd_cnt_err_q;

`ifdef AXI_SYNC_SLICE_STATUS_EN
  assign fifo_empty_flag = {aw_empty, ar_empty, w_empty, r_empty, b_empty};
  assign wr_outstanding  = 8'(wr_cnt_q);
  assign rd_outstanding  = 8'(rd_cnt_q);
`endif

endmodule

// File: tb/tb_axi_sync_slice.sv
// Bench for axi_sync_slice: directed phases with random payloads, every cycle
// compared against a queue-based model of the five channels and two limiters.
module tb_axi_sync_slice;
  import axi_slice_pkg::*;

  localparam int AWD = 4, WD = 16, BD = 4, ARD = 4, RD = 16, MAXW = 4, MAXR = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic wr_cnt_err, rd_cnt_err;
`ifdef AXI_SYNC_SLICE_STATUS_EN
  logic [4:0] fifo_empty_flag;
  logic [7:0] wr_outstanding, rd_outstanding;
`endif

  AXI_INF b_if();
  AXI_INF s_if();

  axi_sync_slice dut (
    .CLK(CLK), .RST(RST), .AXI_B(b_if), .AXI_S(s_if),
    .wr_cnt_err(wr_cnt_err), .rd_cnt_err(rd_cnt_err)
`ifdef AXI_SYNC_SLICE_STATUS_EN
    , .fifo_empty_flag(fifo_empty_flag), .wr_outstanding(wr_outstanding),
    .rd_outstanding(rd_outstanding)
`endif
  );

  always #5 CLK = ~CLK;

  // Stimulus: m_* is the upstream master, s_* the downstream slave.
  logic m_aw_v = 0, m_w_v = 0, m_ar_v = 0, m_b_r = 0, m_r_r = 0;
  logic s_aw_r = 0, s_w_r = 0, s_ar_r = 0, s_b_v = 0, s_r_v = 0;
  ax_t m_aw = '0, m_ar = '0;
  w_t  m_w = '0;
  b_t  s_b = '0;
  r_t  s_r = '0;

  assign {b_if.WR_ADDR_ID, b_if.WR_ADDR, b_if.WR_ADDR_LEN, b_if.WR_ADDR_BURST} = m_aw;
  assign b_if.WR_ADDR_VALID = m_aw_v;
  assign {b_if.WR_DATA, b_if.WR_STRB, b_if.WR_DATA_LAST} = m_w;
  assign b_if.WR_DATA_VALID = m_w_v;
  assign {b_if.RD_ADDR_ID, b_if.RD_ADDR, b_if.RD_ADDR_LEN, b_if.RD_ADDR_BURST} = m_ar;
  assign b_if.RD_ADDR_VALID = m_ar_v;
  assign b_if.WR_BACK_READY = m_b_r;
  assign b_if.RD_DATA_READY = m_r_r;
  assign s_if.WR_ADDR_READY = s_aw_r;
  assign s_if.WR_DATA_READY = s_w_r;
  assign s_if.RD_ADDR_READY = s_ar_r;
  assign {s_if.WR_BACK_ID, s_if.WR_BACK_RESP} = s_b;
  assign s_if.WR_BACK_VALID = s_b_v;
  assign {s_if.RD_BACK_ID, s_if.RD_DATA, s_if.RD_DATA_RESP, s_if.RD_DATA_LAST} = s_r;
  assign s_if.RD_DATA_VALID = s_r_v;

  // Reference model: plain queues and integer counters.
  ax_t awq[$], arq[$];
  w_t  wq[$];
  b_t  bq[$];
  r_t  rq[$];
  int  wcnt = 0, rcnt = 0;
  bit  werr = 0, rerr = 0;
  bit  hs_aw, hs_w, hs_ar, hs_sb, hs_sr;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // One clock: settle, compare outputs to the model, then advance the model.
  task automatic cycle();
    bit e_awr, e_wr, e_arr, e_sbr, e_srr, e_sawv, e_swv, e_sarv, e_bv, e_rv;
    bit b_hs, r_hs, rl;
    #4;
    e_awr  = !RST && awq.size() < AWD && wcnt < MAXW;
    e_wr   = !RST && wq.size()  < WD;
    e_arr  = !RST && arq.size() < ARD && rcnt < MAXR;
    e_sbr  = !RST && bq.size()  < BD;
    e_srr  = !RST && rq.size()  < RD;
    e_sawv = !RST && awq.size() > 0;
    e_swv  = !RST && wq.size()  > 0;
    e_sarv = !RST && arq.size() > 0;
    e_bv   = !RST && bq.size()  > 0;
    e_rv   = !RST && rq.size()  > 0;
    if (chk_en) begin
      check("ready", {b_if.WR_ADDR_READY, b_if.WR_DATA_READY, b_if.RD_ADDR_READY,
                      s_if.WR_BACK_READY, s_if.RD_DATA_READY},
                     {e_awr, e_wr, e_arr, e_sbr, e_srr});
      check("valid", {s_if.WR_ADDR_VALID, s_if.WR_DATA_VALID, s_if.RD_ADDR_VALID,
                      b_if.WR_BACK_VALID, b_if.RD_DATA_VALID},
                     {e_sawv, e_swv, e_sarv, e_bv, e_rv});
      check("err", {wr_cnt_err, rd_cnt_err}, {werr, rerr});
      if (e_sawv)
        check("aw_head", {s_if.WR_ADDR_ID, s_if.WR_ADDR, s_if.WR_ADDR_LEN, s_if.WR_ADDR_BURST}, awq[0]);
      if (e_sarv)
        check("ar_head", {s_if.RD_ADDR_ID, s_if.RD_ADDR, s_if.RD_ADDR_LEN, s_if.RD_ADDR_BURST}, arq[0]);
      if (e_bv)
        check("b_head", {b_if.WR_BACK_ID, b_if.WR_BACK_RESP}, bq[0]);
      if (e_swv) check("w_head", {s_if.WR_DATA, s_if.WR_STRB, s_if.WR_DATA_LAST}, wq[0]);
      else       check("w_mask", {s_if.WR_DATA, s_if.WR_STRB, s_if.WR_DATA_LAST}, 64'd0);
      if (e_rv)  check("r_head", {b_if.RD_BACK_ID, b_if.RD_DATA, b_if.RD_DATA_RESP, b_if.RD_DATA_LAST}, rq[0]);
      else       check("r_mask", {b_if.RD_BACK_ID, b_if.RD_DATA, b_if.RD_DATA_RESP, b_if.RD_DATA_LAST}, 64'd0);
    end
    @(posedge CLK);
    hs_aw = 0; hs_w = 0; hs_ar = 0; hs_sb = 0; hs_sr = 0;
    if (RST) begin
      awq.delete(); wq.delete(); arq.delete(); bq.delete(); rq.delete();
      wcnt = 0; rcnt = 0; werr = 0; rerr = 0;
    end else begin
      hs_aw = m_aw_v && e_awr;
      hs_w  = m_w_v  && e_wr;
      hs_ar = m_ar_v && e_arr;
      hs_sb = s_b_v  && e_sbr;
      hs_sr = s_r_v  && e_srr;
      b_hs  = e_bv && m_b_r;
      r_hs  = e_rv && m_r_r;
      rl    = r_hs && rq[0].last;
      if (e_sawv && s_aw_r) void'(awq.pop_front());
      if (e_swv  && s_w_r)  void'(wq.pop_front());
      if (e_sarv && s_ar_r) void'(arq.pop_front());
      if (b_hs) void'(bq.pop_front());
      if (r_hs) void'(rq.pop_front());
      if (hs_aw) awq.push_back(m_aw);
      if (hs_w)  wq.push_back(m_w);
      if (hs_ar) arq.push_back(m_ar);
      if (hs_sb) bq.push_back(s_b);
      if (hs_sr) rq.push_back(s_r);
      if (hs_aw && !b_hs) wcnt++;
      else if (b_hs && !hs_aw) begin
        if (wcnt == 0) werr = 1; else wcnt--;
      end
      if (hs_ar && !rl) rcnt++;
      else if (rl && !hs_ar) begin
        if (rcnt == 0) rerr = 1; else rcnt--;
      end
    end
    #1;
  endtask

  function automatic ax_t rnd_ax(input int len);
    ax_t a;
    a.id    = ID_W'($urandom);
    a.addr  = $urandom;
    a.len   = LEN_W'(len);
    a.burst = BURST_W'($urandom_range(0, 2));
    return a;
  endfunction

  function automatic w_t mk_w(input int i);
    w_t w;
    w.data = {16'(i), 16'($urandom)};
    w.strb = STRB_W'($urandom);
    w.last = (i % 4 == 3);
    return w;
  endfunction

  function automatic r_t mk_r(input bit last);
    r_t r;
    r.id   = ID_W'($urandom);
    r.data = $urandom;
    r.resp = RESP_W'($urandom);
    r.last = last;
    return r;
  endfunction

  initial begin
    int idx, acc;

    // Bring the DUT out of its unknown power-up state before checking.
    @(posedge CLK); #1;
    chk_en = 1;

    // Reset held 3 cycles with AW offered: nothing accepted, first READY after release.
    m_aw = rnd_ax(0); m_aw_v = 1;
    repeat (3) cycle();
    RST = 0;
    cycle();
    m_aw_v = 0; s_aw_r = 1;
    repeat (2) cycle();
    s_aw_r = 0;

    // Single AW: visible next cycle, held while the slave stalls.
    m_aw = '{id: 4'd3, addr: 32'h1000_0040, len: 8'd0, burst: 2'd1};
    m_aw_v = 1;
    cycle();
    m_aw_v = 0;
    repeat (3) cycle();
    s_aw_r = 1;
    cycle();
    s_aw_r = 0;
    cycle();

    // W fill: 17 offered, 16 taken; then pop while full; then drain in order.
    idx = 0; m_w = mk_w(0); m_w_v = 1;
    repeat (20) begin
      cycle();
      if (hs_w) begin idx++; m_w = mk_w(idx); end
    end
    s_w_r = 1;
    cycle();
    if (hs_w) begin idx++; m_w = mk_w(idx); end
    repeat (40) begin
      s_w_r = 1'($urandom);
      cycle();
      if (hs_w) begin idx++; m_w = mk_w(idx); end
      if (idx >= 17) m_w_v = 0;
    end
    s_w_r = 1;
    repeat (20) cycle();
    s_w_r = 0;

    // Write limiter from a clean start: 5 AWs, 4 taken, fifth after one B.
    RST = 1; cycle(); RST = 0;
    s_aw_r = 1; m_aw_v = 1; m_aw = rnd_ax(0); acc = 0;
    repeat (8) begin
      cycle();
      if (hs_aw) begin acc++; m_aw = rnd_ax(0); end
      if (acc >= 5) m_aw_v = 0;
    end
    s_b = '{id: 4'd2, resp: 2'd0}; s_b_v = 1;
    cycle();
    s_b_v = 0; m_b_r = 1;
    cycle();
    m_b_r = 0;
    repeat (3) begin
      cycle();
      if (hs_aw) begin acc++; m_aw = rnd_ax(0); end
      if (acc >= 5) m_aw_v = 0;
    end
    m_aw_v = 0; s_aw_r = 0;

    // Read limiter: LEN=3 bursts, counter retires only on LAST beats.
    s_ar_r = 1; m_ar_v = 1; m_ar = rnd_ax(3); acc = 0;
    repeat (6) begin
      cycle();
      if (hs_ar) begin acc++; m_ar = rnd_ax(3); end
    end
    idx = 0; s_r = mk_r(0); s_r_v = 1;
    repeat (60) begin
      m_r_r = 1'($urandom);
      cycle();
      if (hs_ar) begin acc++; m_ar = rnd_ax(3); end
      if (acc >= 6) m_ar_v = 0;
      if (hs_sr) begin idx++; s_r = mk_r(idx % 4 == 3); end
      if (idx >= 8) s_r_v = 0;
    end
    m_r_r = 1; m_ar_v = 0;
    repeat (20) cycle();
    m_r_r = 0; s_ar_r = 0;

    // Underflow errors are sticky; reset with W beats buffered clears all.
    RST = 1; cycle(); RST = 0;
    s_b = '{id: 4'd5, resp: 2'd2}; s_b_v = 1;
    s_r = mk_r(1); s_r_v = 1;
    cycle();
    s_b_v = 0; s_r_v = 0; m_b_r = 1; m_r_r = 1;
    repeat (4) cycle();
    m_b_r = 0; m_r_r = 0;
    idx = 0; m_w = mk_w(100); m_w_v = 1;
    while (idx < 5) begin
      cycle();
      if (hs_w) begin idx++; m_w = mk_w(100 + idx); end
    end
    m_w_v = 0;
    RST = 1; cycle(); RST = 0;
    s_w_r = 1;
    repeat (4) cycle();
    s_w_r = 0;

    // Mixed random traffic on all channels.
    repeat (400) begin
      m_aw_v = 1'($urandom); m_aw = rnd_ax($urandom_range(0, 7));
      m_w_v  = 1'($urandom); m_w  = mk_w($urandom_range(0, 255));
      m_ar_v = 1'($urandom); m_ar = rnd_ax($urandom_range(0, 7));
      s_b_v  = 1'($urandom); s_b  = b_t'($urandom);
      s_r_v  = 1'($urandom); s_r  = mk_r(1'($urandom));
      m_b_r  = 1'($urandom); m_r_r = 1'($urandom);
      s_aw_r = 1'($urandom); s_w_r = 1'($urandom); s_ar_r = 1'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
